// File: rtl/coin_lane_scheduler.sv
// Per-frame sequencer for the three lane coin sprites: spawning, fall motion,
// perspective scale, pickup/miss detection and score keeping.
module coin_lane_scheduler #(
    parameter logic [15:0] Y_START   = 16'd0,
    parameter logic [15:0] Y_END     = 16'd592,
    parameter logic [15:0] SCALE2_Y  = 16'd300,
    parameter logic [15:0] SCALE4_Y  = 16'd450,
    parameter logic [15:0] HIT_Y_MIN = 16'd500,
    parameter int          SPAWN_GAP = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_tick,
    input  logic        i_enable,
    input  logic [1:0]  i_penguin_lane,
    output logic [2:0]  o_coin_active,
    output logic [47:0] o_coin_y,
    output logic [5:0]  o_coin_scale,
    output logic [15:0] o_score,
    output logic        o_score_pulse,
    output logic        o_miss_pulse,
    output logic [2:0]  o_miss_lanes
);

    localparam logic [15:0] Y_PARK = 16'd1000;
    localparam int GAP_W = $clog2(SPAWN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_GAP);

    typedef enum logic {IDLE, FALL} lane_state_t;

    lane_state_t      state      [3];
    lane_state_t      state_next [3];
    logic [15:0]      y          [3];
    logic [15:0]      y_next     [3];
    logic [1:0]       scale      [3];
    logic [1:0]       scale_next [3];
    logic [15:0]      score, score_next;
    logic             score_pulse, score_pulse_next;
    logic             miss_pulse, miss_pulse_next;
    logic [2:0]       miss_lanes, miss_lanes_next;
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic [15:0]      lfsr, lfsr_next;

    logic       update;
    logic [2:0] idle_pre;
    logic [2:0] collect;
    logic [2:0] miss;
    logic       spawn;
    logic [1:0] spawn_lane;

    function automatic logic [1:0] scale_of(input logic [15:0] yv);
        if (yv < SCALE2_Y)      scale_of = 2'd0;
        else if (yv < SCALE4_Y) scale_of = 2'd1;
        else                    scale_of = 2'd2;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Candidate 3 folds onto lane 0; search wraps c, c+1, c+2 modulo 3.
    function automatic logic [1:0] pick_lane(input logic [2:0] idle, input logic [1:0] raw);
        logic [1:0] c;
        logic [2:0] s;
        c = (raw == 2'd3) ? 2'd0 : raw;
        pick_lane = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, c} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (idle[s[1:0]]) pick_lane = s[1:0];
        end
    endfunction

    assign update = i_frame_tick & i_enable;

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            state_next[n] = state[n];
            y_next[n]     = y[n];
            scale_next[n] = scale[n];
            idle_pre[n]   = (state[n] == IDLE);
            collect[n]    = 1'b0;
            miss[n]       = 1'b0;
        end
        score_next       = score;
        score_pulse_next = 1'b0;
        miss_pulse_next  = 1'b0;
        miss_lanes_next  = miss_lanes;
        gap_next         = gap_cnt;
        lfsr_next        = lfsr;
        spawn            = 1'b0;
        spawn_lane       = pick_lane(idle_pre, lfsr[1:0]);

        if (update) begin
            for (int n = 0; n < 3; n++) begin
                if (state[n] == FALL) begin
                    if (y[n] > HIT_Y_MIN && y[n] < Y_END && i_penguin_lane == 2'(n)) begin
                        collect[n]    = 1'b1;
                        state_next[n] = IDLE;
                        y_next[n]     = Y_PARK;
                        scale_next[n] = 2'd0;
                    end else if (y[n] == Y_END) begin
                        miss[n]       = 1'b1;
                        state_next[n] = IDLE;
                        y_next[n]     = Y_PARK;
                        scale_next[n] = 2'd0;
                    end else begin
                        y_next[n]     = y[n] + 16'd1;
                        scale_next[n] = scale_of(y[n] + 16'd1);
                    end
                end
            end

            if (|collect) begin
                score_pulse_next = 1'b1;
                if (score != 16'hFFFF) score_next = score + 16'd1;
            end
            if (|miss) begin
                miss_pulse_next = 1'b1;
                miss_lanes_next = miss;
            end

            // Eligibility uses the pre-tick idle set, so a lane freed above waits a tick.
            if (gap_cnt >= GAP_MAX && |idle_pre) begin
                spawn     = 1'b1;
                gap_next  = '0;
                lfsr_next = lfsr_step(lfsr);
                for (int n = 0; n < 3; n++) begin
                    if (spawn_lane == 2'(n)) begin
                        state_next[n] = FALL;
                        y_next[n]     = Y_START;
                        scale_next[n] = 2'd0;
                    end
                end
            end else begin
                gap_next = (gap_cnt >= GAP_MAX) ? GAP_MAX : gap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int n = 0; n < 3; n++) begin
                state[n] <= IDLE;
                y[n]     <= Y_PARK;
                scale[n] <= 2'd0;
            end
            score       <= '0;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            miss_lanes  <= '0;
            gap_cnt     <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            for (int n = 0; n < 3; n++) begin
                state[n] <= state_next[n];
                y[n]     <= y_next[n];
                scale[n] <= scale_next[n];
            end
            score       <= score_next;
            score_pulse <= score_pulse_next;
            miss_pulse  <= miss_pulse_next;
            miss_lanes  <= miss_lanes_next;
            gap_cnt     <= gap_next;
            lfsr        <= lfsr_next;
        end
    end

    assign o_coin_active = {state[2] == FALL, state[1] == FALL, state[0] == FALL};
    assign o_coin_y      = {y[2], y[1], y[0]};
    assign o_coin_scale  = {scale[2], scale[1], scale[0]};
    assign o_score       = score;
    assign o_score_pulse = score_pulse;
    assign o_miss_pulse  = miss_pulse;
    assign o_miss_lanes  = miss_lanes;

endmodule

// File: tb/tb_coin_lane_scheduler.sv
// Directed bench for coin_lane_scheduler: spawn order, fall, scale steps,
// collect, miss, spawn blocking, enable freeze and asynchronous reset.
module tb_coin_lane_scheduler;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_frame_tick;
    logic        i_enable;
    logic [1:0]  i_penguin_lane;
    logic [2:0]  o_coin_active;
    logic [47:0] o_coin_y;
    logic [5:0]  o_coin_scale;
    logic [15:0] o_score;
    logic        o_score_pulse;
    logic        o_miss_pulse;
    logic [2:0]  o_miss_lanes;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_n   = 0;

    coin_lane_scheduler dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_frame_tick   (i_frame_tick),
        .i_enable       (i_enable),
        .i_penguin_lane (i_penguin_lane),
        .o_coin_active  (o_coin_active),
        .o_coin_y       (o_coin_y),
        .o_coin_scale   (o_coin_scale),
        .o_score        (o_score),
        .o_score_pulse  (o_score_pulse),
        .o_miss_pulse   (o_miss_pulse),
        .o_miss_lanes   (o_miss_lanes)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ly(input int n);
        return o_coin_y[16*n +: 16];
    endfunction

    function automatic logic [1:0] lsc(input int n);
        return o_coin_scale[2*n +: 2];
    endfunction

    task automatic do_tick(input logic en);
        i_enable     = en;
        i_frame_tick = 1'b1;
        @(negedge i_clk);
        i_frame_tick = 1'b0;
        i_enable     = 1'b1;
    endtask

    task automatic run_to(input int t);
        while (tick_n < t) begin
            do_tick(1'b1);
            tick_n++;
        end
    endtask

    initial begin
        i_reset        = 1'b1;
        i_frame_tick   = 1'b0;
        i_enable       = 1'b1;
        i_penguin_lane = 2'd3;
        repeat (2) @(negedge i_clk);
        check("rst_active", 64'(o_coin_active), 64'd0);
        check("rst_y", 64'(o_coin_y), 64'({3{16'd1000}}));
        check("rst_scale", 64'(o_coin_scale), 64'd0);
        check("rst_score", 64'(o_score), 64'd0);
        check("rst_pulses", 64'({o_score_pulse, o_miss_pulse, o_miss_lanes}), 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        run_to(60);
        check("t60_active", 64'(o_coin_active), 64'd0);
        check("t60_y", 64'(o_coin_y), 64'({3{16'd1000}}));

        run_to(61);
        check("t61_active", 64'(o_coin_active), 64'b010);
        check("t61_y1", 64'(ly(1)), 64'd0);
        check("t61_scale", 64'(o_coin_scale), 64'd0);

        run_to(70);
        check("t70_y1", 64'(ly(1)), 64'd9);

        run_to(122);
        check("t122_active", 64'(o_coin_active), 64'b011);
        check("t122_y0", 64'(ly(0)), 64'd0);
        check("t122_lfsr", 64'(dut.lfsr), 64'h59C3 == 64'h0 ? 64'h0 : 64'hB387);

        run_to(130);
        check("t130_y1", 64'(ly(1)), 64'd69);
        check("t130_y0", 64'(ly(0)), 64'd8);

        repeat (20) do_tick(1'b0);
        check("frz_y1", 64'(ly(1)), 64'd69);
        check("frz_y0", 64'(ly(0)), 64'd8);
        check("frz_gap", 64'(dut.gap_cnt), 64'd8);
        check("frz_lfsr", 64'(dut.lfsr), 64'hB387);
        check("frz_active", 64'(o_coin_active), 64'b011);

        run_to(183);
        check("t183_active", 64'(o_coin_active), 64'b111);
        check("t183_y2", 64'(ly(2)), 64'd0);

        run_to(250);
        check("t250_gap_sat", 64'(dut.gap_cnt), 64'd60);
        check("t250_active", 64'(o_coin_active), 64'b111);

        run_to(421);
        check("t421_y0", 64'(ly(0)), 64'd299);
        check("t421_sc0", 64'(lsc(0)), 64'd0);
        run_to(422);
        check("t422_y0", 64'(ly(0)), 64'd300);
        check("t422_sc0", 64'(lsc(0)), 64'd1);

        run_to(556);
        check("t556_y1", 64'(ly(1)), 64'd495);
        i_penguin_lane = 2'd1;
        run_to(562);
        check("t562_y1", 64'(ly(1)), 64'd501);
        check("t562_score", 64'(o_score), 64'd0);
        run_to(563);
        check("col_score", 64'(o_score), 64'd1);
        check("col_pulse", 64'(o_score_pulse), 64'd1);
        check("col_active", 64'(o_coin_active), 64'b101);
        check("col_y1", 64'(ly(1)), 64'd1000);
        check("col_gap", 64'(dut.gap_cnt), 64'd60);
        @(negedge i_clk);
        check("col_pulse_clr", 64'(o_score_pulse), 64'd0);
        i_penguin_lane = 2'd3;

        run_to(564);
        check("t564_active", 64'(o_coin_active), 64'b111);
        check("t564_y1", 64'(ly(1)), 64'd0);

        run_to(571);
        check("t571_y0", 64'(ly(0)), 64'd449);
        check("t571_sc0", 64'(lsc(0)), 64'd1);
        run_to(572);
        check("t572_y0", 64'(ly(0)), 64'd450);
        check("t572_sc0", 64'(lsc(0)), 64'd2);

        run_to(714);
        check("t714_y0", 64'(ly(0)), 64'd592);
        check("t714_miss", 64'(o_miss_pulse), 64'd0);
        run_to(715);
        check("miss_pulse", 64'(o_miss_pulse), 64'd1);
        check("miss_lanes", 64'(o_miss_lanes), 64'b001);
        check("miss_y0", 64'(ly(0)), 64'd1000);
        check("miss_sc0", 64'(lsc(0)), 64'd0);
        check("miss_active", 64'(o_coin_active), 64'b110);
        check("miss_score", 64'(o_score), 64'd1);
        @(negedge i_clk);
        check("miss_pulse_clr", 64'(o_miss_pulse), 64'd0);
        check("miss_lanes_hold", 64'(o_miss_lanes), 64'b001);

        run_to(720);
        #2 i_reset = 1'b1;
        #1;
        check("arst_active", 64'(o_coin_active), 64'd0);
        check("arst_y", 64'(o_coin_y), 64'({3{16'd1000}}));
        check("arst_scale", 64'(o_coin_scale), 64'd0);
        check("arst_score", 64'(o_score), 64'd0);
        check("arst_miss_lanes", 64'(o_miss_lanes), 64'd0);
        check("arst_lfsr", 64'(dut.lfsr), 64'hACE1);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
